// File: rtl/mips_mem_bridge.sv
// M-stage data-memory bridge: turns lw/lh/lb/sw/sh/sb into req/ack bus transactions and
// stalls the pipeline until the access completes or times out.
module mips_mem_bridge #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255,
    parameter bit BIG_ENDIAN  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memtoregM,
    input  logic              memwriteM,
    input  logic [2:0]        lshbM,
    input  logic [31:0]       aluoutM,
    input  logic [31:0]       writedataM,
    output logic [31:0]       readdataM,
    output logic              stallM,
    output logic              adelM,
    output logic              adesM,
    output logic              bus_errM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        dbgState
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       laneQ;
    logic             hLaneQ, isByteQ, isHalfQ, isSignedQ;

    logic        access, isHalf, isByte, isSigned, misaligned, hLane;
    logic [1:0]  lane;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [7:0]  rByte;
    logic [15:0] rHalf;
    logic [31:0] loadData;

    // Decode of the M-stage instruction; only acted on while IDLE.
    always_comb begin
        access     = memtoregM | memwriteM;
        isHalf     = (lshbM == 3'b001) || (lshbM == 3'b010);
        isByte     = (lshbM == 3'b011) || (lshbM == 3'b100);
        isSigned   = (lshbM == 3'b001) || (lshbM == 3'b011);
        lane       = BIG_ENDIAN ? (2'd3 - aluoutM[1:0]) : aluoutM[1:0];
        hLane      = BIG_ENDIAN ? ~aluoutM[1] : aluoutM[1];
        misaligned = isHalf ? aluoutM[0] : (isByte ? 1'b0 : (aluoutM[1:0] != 2'b00));
        if (isByte) begin
            strb  = 4'b0001 << lane;
            wdata = {4{writedataM[7:0]}};
        end else if (isHalf) begin
            strb  = hLane ? 4'b1100 : 4'b0011;
            wdata = {2{writedataM[15:0]}};
        end else begin
            strb  = 4'b1111;
            wdata = writedataM;
        end
        if (!memwriteM) strb = 4'b0000;
    end

    always_comb begin
        rByte = 8'h00;
        case (laneQ)
            2'd0: rByte = mem_rdata[7:0];
            2'd1: rByte = mem_rdata[15:8];
            2'd2: rByte = mem_rdata[23:16];
            2'd3: rByte = mem_rdata[31:24];
            default: rByte = 8'h00;
        endcase
        rHalf = hLaneQ ? mem_rdata[31:16] : mem_rdata[15:0];
        if (isByteQ)      loadData = {{24{isSignedQ & rByte[7]}}, rByte};
        else if (isHalfQ) loadData = {{16{isSignedQ & rHalf[15]}}, rHalf};
        else              loadData = mem_rdata;
    end

    assign adelM    = (state == IDLE) && access && misaligned && !memwriteM;
    assign adesM    = (state == IDLE) && access && misaligned && memwriteM;
    assign stallM   = ((state == IDLE) && access && !misaligned) || (state == REQ);
    assign dbgState = state;

    // Handshake: mem_req rises with every bus field valid and holds them stable until the
    // edge that samples mem_ack=1 (or the timeout); mem_ack is honoured only in REQ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wstrb <= 4'b0000;
            mem_wdata <= 32'h0;
            bus_errM  <= 1'b0;
            readdataM <= 32'h0;
            laneQ     <= 2'd0;
            hLaneQ    <= 1'b0;
            isByteQ   <= 1'b0;
            isHalfQ   <= 1'b0;
            isSignedQ <= 1'b0;
        end else begin
            bus_errM <= 1'b0;
            case (state)
                IDLE: begin
                    if (access && !misaligned) begin
                        state     <= REQ;
                        cnt       <= '0;
                        mem_req   <= 1'b1;
                        mem_we    <= memwriteM;
                        mem_addr  <= {aluoutM[ADDR_W-1:2], 2'b00};
                        mem_wstrb <= strb;
                        mem_wdata <= wdata;
                        laneQ     <= lane;
                        hLaneQ    <= hLane;
                        isByteQ   <= isByte;
                        isHalfQ   <= isHalf;
                        isSignedQ <= isSigned;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (!mem_we) readdataM <= loadData;
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end else if ((TIMEOUT_CYC != 0) && (cnt == TO_LAST)) begin
                        mem_req   <= 1'b0;
                        bus_errM  <= 1'b1;
                        readdataM <= 32'h0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mem_bridge.sv
// Bench for mips_mem_bridge: a little-endian DUT with a short timeout and a big-endian DUT
// that never times out, sharing pipeline inputs and checked against a byte-level memory model.
module tb_mips_mem_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        memtoregM = 1'b0, memwriteM = 1'b0;
    logic [2:0]  lshbM = 3'd0;
    logic [31:0] aluoutM = 32'h0, writedataM = 32'h0, mem_rdata = 32'h0;
    logic        ack0 = 1'b0, ack1 = 1'b0;

    logic [31:0] readdata0, readdata1, addr0, addr1, wdata0, wdata1;
    logic        stall0, stall1, adel0, adel1, ades0, ades1, berr0, berr1;
    logic        req0, req1, we0, we1;
    logic [3:0]  strb0, strb1;
    logic [1:0]  dbg0, dbg1;

    int          nVec = 0;
    int          nErr = 0;
    logic [31:0] rdExpL = 32'h0;
    logic [31:0] rdExpB = 32'h0;

    always #5 clk = ~clk;

    mips_mem_bridge #(.ADDR_W(32), .TIMEOUT_CYC(4), .BIG_ENDIAN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .memtoregM(memtoregM), .memwriteM(memwriteM), .lshbM(lshbM),
        .aluoutM(aluoutM), .writedataM(writedataM), .readdataM(readdata0), .stallM(stall0),
        .adelM(adel0), .adesM(ades0), .bus_errM(berr0), .mem_req(req0), .mem_we(we0),
        .mem_addr(addr0), .mem_wstrb(strb0), .mem_wdata(wdata0), .mem_ack(ack0),
        .mem_rdata(mem_rdata), .dbgState(dbg0)
    );

    mips_mem_bridge #(.ADDR_W(32), .TIMEOUT_CYC(0), .BIG_ENDIAN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .memtoregM(memtoregM), .memwriteM(memwriteM), .lshbM(lshbM),
        .aluoutM(aluoutM), .writedataM(writedataM), .readdataM(readdata1), .stallM(stall1),
        .adelM(adel1), .adesM(ades1), .bus_errM(berr1), .mem_req(req1), .mem_we(we1),
        .mem_addr(addr1), .mem_wstrb(strb1), .mem_wdata(wdata1), .mem_ack(ack1),
        .mem_rdata(mem_rdata), .dbgState(dbg1)
    );

    // ---------------- reference model ----------------
    function automatic int sizeOf(input logic [2:0] sz);
        case (sz)
            3'd1, 3'd2: return 2;
            3'd3, 3'd4: return 1;
            default:    return 4;
        endcase
    endfunction

    // Index of the least significant byte of the accessed item within the bus word.
    function automatic int byteIdx(input logic [2:0] sz, input logic [31:0] addr, input bit big);
        int n, off;
        n = sizeOf(sz);
        off = int'(addr % 4);
        return big ? (4 - n - off) : off;
    endfunction

    function automatic logic [31:0] itemMask(input logic [2:0] sz);
        int n;
        n = sizeOf(sz);
        return (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] sz, input logic [31:0] addr,
                                              input logic [31:0] rd, input bit big);
        logic [31:0] m, v;
        int n;
        n = sizeOf(sz);
        m = itemMask(sz);
        v = (rd >> (8 * byteIdx(sz, addr, big))) & m;
        if ((sz == 3'd1 || sz == 3'd3) && v[8 * n - 1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic [3:0] modelStrb(input logic [2:0] sz, input logic [31:0] addr, input bit big);
        int n;
        n = sizeOf(sz);
        return 4'(((1 << n) - 1) << byteIdx(sz, addr, big));
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = sizeOf(sz);
        r = 32'h0;
        for (int i = 0; i < 4 / n; i++) r = r | ((wd & itemMask(sz)) << (8 * n * i));
        return r;
    endfunction

    // ---------------- driver ----------------
    // Drives one M-stage access at a negedge in IDLE; the memory acks in REQ cycle w (0-based).
    task automatic do_access(input logic ld, input logic st, input logic [2:0] sz,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rd, input int w);
        bit          isSt, mis;
        logic [3:0]  sL, sB;
        logic [31:0] wdx;
        isSt = st;
        mis  = (addr % sizeOf(sz)) != 0;
        sL   = isSt ? modelStrb(sz, addr, 1'b0) : 4'b0000;
        sB   = isSt ? modelStrb(sz, addr, 1'b1) : 4'b0000;
        wdx  = modelWdata(sz, wd);
        memtoregM = ld; memwriteM = st; lshbM = sz; aluoutM = addr; writedataM = wd; mem_rdata = rd;
        #1;
        if (mis) begin
            nVec++;
            if ({stall0, adel0, ades0, stall1, adel1, ades1} !== {1'b0, !isSt, isSt, 1'b0, !isSt, isSt}) begin
                nErr++;
                $display("FAIL misaligned_flags addr=%h sz=%0d got=%b exp=%b", addr, sz,
                         {stall0, adel0, ades0, stall1, adel1, ades1}, {1'b0, !isSt, isSt, 1'b0, !isSt, isSt});
            end
            @(negedge clk);
            nVec++;
            if ({req0, req1, stall0, stall1} !== 4'b0000) begin
                nErr++;
                $display("FAIL misaligned_noreq addr=%h got=%b exp=0000", addr, {req0, req1, stall0, stall1});
            end
            memtoregM = 1'b0; memwriteM = 1'b0;
            return;
        end
        nVec++;
        if ({stall0, stall1, adel0, ades0, adel1, ades1} !== 6'b110000) begin
            nErr++;
            $display("FAIL idle_stall addr=%h got=%b exp=110000", addr, {stall0, stall1, adel0, ades0, adel1, ades1});
        end
        @(negedge clk);
        for (int k = 0; k <= w; k++) begin
            nVec++;
            if ({stall0, req0, we0, addr0, strb0} !== {1'b1, 1'b1, isSt, addr & ~32'd3, sL}) begin
                nErr++;
                $display("FAIL bus_le cyc=%0d got=%b_%b_%b_%h_%b exp=1_1_%b_%h_%b", k, stall0, req0, we0,
                         addr0, strb0, isSt, addr & ~32'd3, sL);
            end
            nVec++;
            if ({stall1, req1, we1, addr1, strb1} !== {1'b1, 1'b1, isSt, addr & ~32'd3, sB}) begin
                nErr++;
                $display("FAIL bus_be cyc=%0d got=%b_%b_%b_%h_%b exp=1_1_%b_%h_%b", k, stall1, req1, we1,
                         addr1, strb1, isSt, addr & ~32'd3, sB);
            end
            if (isSt) begin
                nVec++;
                if ({wdata0, wdata1} !== {wdx, wdx}) begin
                    nErr++;
                    $display("FAIL store_wdata got=%h/%h exp=%h", wdata0, wdata1, wdx);
                end
            end
            if (k == w) begin ack0 = 1'b1; ack1 = 1'b1; end
            @(negedge clk);
            ack0 = 1'b0; ack1 = 1'b0;
        end
        if (ld && !st) begin
            rdExpL = modelLoad(sz, addr, rd, 1'b0);
            rdExpB = modelLoad(sz, addr, rd, 1'b1);
        end
        nVec++;
        if ({stall0, req0, berr0, stall1, req1, berr1} !== 6'b000000) begin
            nErr++;
            $display("FAIL done_ctl got=%b exp=000000", {stall0, req0, berr0, stall1, req1, berr1});
        end
        nVec++;
        if (readdata0 !== rdExpL) begin
            nErr++;
            $display("FAIL readdata_le addr=%h sz=%0d got=%h exp=%h", addr, sz, readdata0, rdExpL);
        end
        nVec++;
        if (readdata1 !== rdExpB) begin
            nErr++;
            $display("FAIL readdata_be addr=%h sz=%0d got=%h exp=%h", addr, sz, readdata1, rdExpB);
        end
        memtoregM = 1'b0; memwriteM = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        nVec++;
        if ({req0, we0, strb0, berr0, readdata0, addr0, wdata0, stall0} !== 104'h0) begin
            nErr++;
            $display("FAIL reset_le got=%b_%b_%b_%b_%h_%h_%h", req0, we0, strb0, berr0, readdata0, addr0, wdata0);
        end
        nVec++;
        if ({req1, we1, strb1, berr1, readdata1, addr1, wdata1, stall1} !== 104'h0) begin
            nErr++;
            $display("FAIL reset_be got=%b_%b_%b_%b_%h_%h_%h", req1, we1, strb1, berr1, readdata1, addr1, wdata1);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_loads();
        do_access(1'b1, 1'b0, 3'd0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        nVec++;
        if (readdata0 !== 32'hDEADBEEF) begin nErr++; $display("FAIL lw_example got=%h exp=deadbeef", readdata0); end
        do_access(1'b1, 1'b0, 3'd3, 32'h103, 32'h0, 32'h80112233, 1);
        nVec++;
        if ({readdata0, readdata1} !== {32'hFFFFFF80, 32'h00000033}) begin
            nErr++; $display("FAIL lb_example got=%h/%h exp=ffffff80/00000033", readdata0, readdata1);
        end
        do_access(1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 32'h80112233, 2);
        nVec++;
        if (readdata0 !== 32'h00000080) begin nErr++; $display("FAIL lbu_example got=%h exp=00000080", readdata0); end
        do_access(1'b1, 1'b0, 3'd1, 32'h102, 32'h0, 32'h80112233, 3);
        nVec++;
        if (readdata0 !== 32'hFFFF8011) begin nErr++; $display("FAIL lh_example got=%h exp=ffff8011", readdata0); end
    endtask

    task automatic test_stores();
        do_access(1'b0, 1'b1, 3'd3, 32'h101, 32'h000000A5, 32'h0, 0);
        do_access(1'b0, 1'b1, 3'd1, 32'h102, 32'h1234ABCD, 32'h0, 1);
        do_access(1'b1, 1'b1, 3'd0, 32'h104, 32'hCAFEF00D, 32'h55555555, 0);
    endtask

    task automatic test_misaligned();
        do_access(1'b1, 1'b0, 3'd0, 32'h102, 32'h0, 32'h0, 0);
        do_access(1'b0, 1'b1, 3'd1, 32'h101, 32'h0, 32'h0, 0);
        do_access(1'b1, 1'b0, 3'd2, 32'h103, 32'h0, 32'h0, 0);
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        rd = $urandom;
        memtoregM = 1'b1; memwriteM = 1'b0; lshbM = 3'd0; aluoutM = 32'h200; mem_rdata = rd;
        #1;
        nVec++;
        if ({stall0, stall1} !== 2'b11) begin nErr++; $display("FAIL to_start got=%b exp=11", {stall0, stall1}); end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            nVec++;
            if ({req0, req1, berr0} !== 3'b110) begin
                nErr++; $display("FAIL to_req cyc=%0d got=%b exp=110", k, {req0, req1, berr0});
            end
            @(negedge clk);
        end
        rdExpL = 32'h0;
        nVec++;
        if ({berr0, req0, stall0, readdata0, req1, stall1} !== {3'b100, 32'h0, 2'b11}) begin
            nErr++;
            $display("FAIL to_abort got=%b_%b_%b_%h_%b_%b exp=1_0_0_00000000_1_1", berr0, req0, stall0,
                     readdata0, req1, stall1);
        end
        memtoregM = 1'b0;
        @(negedge clk);
        nVec++;
        if ({berr0, req0, stall0} !== 3'b000) begin
            nErr++; $display("FAIL to_pulse got=%b exp=000", {berr0, req0, stall0});
        end
        for (int k = 0; k < 6; k++) begin
            nVec++;
            if ({req1, berr1} !== 2'b10) begin nErr++; $display("FAIL notimeout_hold got=%b exp=10", {req1, berr1}); end
            @(negedge clk);
        end
        ack0 = 1'b1; ack1 = 1'b1;
        @(negedge clk);
        ack0 = 1'b0; ack1 = 1'b0;
        rdExpB = rd;
        nVec++;
        if ({req0, stall0, berr0, readdata0} !== {3'b000, 32'h0}) begin
            nErr++; $display("FAIL idle_ack_le got=%b_%b_%b_%h exp=0_0_0_00000000", req0, stall0, berr0, readdata0);
        end
        nVec++;
        if ({req1, berr1, readdata1} !== {2'b00, rdExpB}) begin
            nErr++; $display("FAIL late_ack_be got=%b_%b_%h exp=0_0_%h", req1, berr1, readdata1, rdExpB);
        end
        @(negedge clk);
        do_access(1'b1, 1'b0, 3'd0, 32'h204, 32'h0, 32'h0BADF00D, 3);
    endtask

    task automatic test_ack_ignored();
        for (int k = 0; k < 3; k++) begin
            mem_rdata = $urandom;
            ack0 = 1'b1; ack1 = 1'b1;
            @(negedge clk);
            nVec++;
            if ({req0, req1, stall0, stall1, readdata0, readdata1} !== {4'b0000, rdExpL, rdExpB}) begin
                nErr++;
                $display("FAIL stray_ack got=%b_%h_%h exp=0000_%h_%h", {req0, req1, stall0, stall1},
                         readdata0, readdata1, rdExpL, rdExpB);
            end
        end
        ack0 = 1'b0; ack1 = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        memtoregM = 1'b1; memwriteM = 1'b0; lshbM = 3'd0; aluoutM = 32'h300;
        @(negedge clk);
        nVec++;
        if ({req0, req1} !== 2'b11) begin nErr++; $display("FAIL rst_pre_req got=%b exp=11", {req0, req1}); end
        @(negedge clk);
        rst = 1'b0; memtoregM = 1'b0;
        #1;
        rdExpL = 32'h0; rdExpB = 32'h0;
        nVec++;
        if ({req0, req1, stall0, stall1, readdata0, readdata1} !== {4'b0000, 64'h0}) begin
            nErr++; $display("FAIL rst_withdraw got=%b_%h_%h exp=0000_0_0", {req0, req1, stall0, stall1},
                             readdata0, readdata1);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        mem_rdata = 32'h13572468;
        ack0 = 1'b1; ack1 = 1'b1;
        @(negedge clk);
        ack0 = 1'b0; ack1 = 1'b0;
        nVec++;
        if ({req0, req1, stall0, stall1, berr0, berr1, readdata0, readdata1} !== {6'b000000, 64'h0}) begin
            nErr++; $display("FAIL rst_late_ack got=%b_%h_%h exp=000000_0_0",
                             {req0, req1, stall0, stall1, berr0, berr1}, readdata0, readdata1);
        end
        do_access(1'b1, 1'b0, 3'd2, 32'h302, 32'h0, 32'h8001FFFE, 0);
    endtask

    task automatic test_back_to_back();
        logic        ld, st;
        logic [2:0]  sz;
        for (int i = 0; i < 60; i++) begin
            ld = 1'($urandom_range(0, 1));
            st = ld ? 1'($urandom_range(0, 1)) : 1'b1;
            sz = 3'($urandom_range(0, 7));
            do_access(ld, st, sz, 32'h1000 + $urandom_range(0, 255), $urandom, $urandom, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_misaligned();
        test_timeout();
        test_ack_ignored();
        test_reset_mid_access();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
